// File: rtl/mem_access_if.sv
// mem_access_if: request/acknowledge data bus between the MEM stage and memory.
//   bus_req   : request strobe, held until bus_ack
//   bus_we    : write enable (stores)
//   bus_addr  : word-aligned byte address
//   bus_sel   : big-endian byte lane enables
//   bus_wdata : store data, replicated across lanes
//   bus_ack   : access complete
//   bus_rdata : read data, valid with bus_ack
// master = MEM stage, slave = memory.
interface mem_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: MIPS memory-access stage (ex_mem -> mem_wb).
// Issues loads/stores on a req/ack bus, selects big-endian byte lanes,
// sign/zero-extends load data and handles the LL/SC link bit. Holds the
// pipeline through stallreq until the access completes.
// Optional feature macro: LLSC_EN (LL/SC link-bit semantics). When it is
// undefined, LL acts as LW, SC acts as SW writing 1 to rt, and the LLbit
// inputs are ignored.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   em_*                : instruction fields from ex_mem
//   stall[5:0]          : ctrl stall vector, bit 4 is this stage
//   LLbit_i, wb_LLbit_* : LLbit register value and WB-stage forwarding
//   bus                 : mem_access_if master
//   mem_*               : result to mem_wb
//   stallreq            : hold request to ctrl
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        em_reg,
  input  logic [4:0]  em_waddr,
  input  logic [31:0] em_wdata,
  input  logic        em_whilo,
  input  logic [31:0] em_hi,
  input  logic [31:0] em_lo,
  input  logic [7:0]  em_aluop,
  input  logic [31:0] em_mem_addr,
  input  logic [31:0] em_reg2,
  input  logic [5:0]  stall,
  input  logic        LLbit_i,
  input  logic        wb_LLbit_we,
  input  logic        wb_LLbit_value,
  mem_access_if.master bus,
  output logic        mem_reg,
  output logic [4:0]  mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_LLbit_we,
  output logic        mem_LLbit_value,
  output logic        stallreq
);

  localparam logic       WriteDisa  = 1'b0;
  localparam logic [4:0] NOPRegAddr = 5'b00000;
  localparam logic       NoStop     = 1'b0;

  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_LL_OP  = 8'b11110000;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
  localparam logic [7:0] EXE_SC_OP  = 8'b11111000;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_bus_req, w_bus_req_nxt;
  logic        r_bus_we, w_bus_we_nxt;
  logic [31:0] r_bus_addr, w_bus_addr_nxt;
  logic [3:0]  r_bus_sel, w_bus_sel_nxt;
  logic [31:0] r_bus_wdata, w_bus_wdata_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic        r_sc_ok, w_sc_ok_nxt;

  logic        w_is_load, w_is_store, w_is_sc, w_is_ll, w_is_mem;
  logic        w_misalign;
  logic [3:0]  w_sel;
  logic [31:0] w_st_data;
  logic [31:0] w_ld_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_llbit;
  logic        w_sc_ok;
  logic        w_go;
  logic        w_unused_stall;

  assign w_unused_stall = ^{stall[5], stall[3:0]};

`ifdef LLSC_EN
  assign w_llbit = wb_LLbit_we ? wb_LLbit_value : LLbit_i;
`else
  logic w_unused_llsc;
  assign w_llbit       = 1'b1;
  assign w_unused_llsc = ^{LLbit_i, wb_LLbit_we, wb_LLbit_value, w_is_ll};
`endif

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_sel   = r_bus_sel;
  assign bus.bus_wdata = r_bus_wdata;

  // Decode: lane selection, store replication, load extension from the
  // latched read data.
  always_comb begin
    case (em_mem_addr[1:0])
      2'b00:   w_byte = r_rdata[31:24];
      2'b01:   w_byte = r_rdata[23:16];
      2'b10:   w_byte = r_rdata[15:8];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half     = em_mem_addr[1] ? r_rdata[15:0] : r_rdata[31:16];
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_is_sc    = 1'b0;
    w_is_ll    = 1'b0;
    w_misalign = 1'b0;
    w_sel      = '0;
    w_st_data  = '0;
    w_ld_data  = '0;
    case (em_aluop)
      EXE_LB_OP, EXE_LBU_OP: begin
        w_is_load = 1'b1;
        w_sel     = 4'b1000 >> em_mem_addr[1:0];
        w_ld_data = (em_aluop == EXE_LB_OP) ? {{24{w_byte[7]}}, w_byte}
                                            : {24'h000000, w_byte};
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        w_is_load  = 1'b1;
        w_misalign = em_mem_addr[0];
        w_sel      = em_mem_addr[1] ? 4'b0011 : 4'b1100;
        w_ld_data  = (em_aluop == EXE_LH_OP) ? {{16{w_half[15]}}, w_half}
                                             : {16'h0000, w_half};
      end
      EXE_LW_OP, EXE_LL_OP: begin
        w_is_load  = 1'b1;
        w_is_ll    = (em_aluop == EXE_LL_OP);
        w_misalign = |em_mem_addr[1:0];
        w_sel      = 4'b1111;
        w_ld_data  = r_rdata;
      end
      EXE_SB_OP: begin
        w_is_store = 1'b1;
        w_sel      = 4'b1000 >> em_mem_addr[1:0];
        w_st_data  = {4{em_reg2[7:0]}};
      end
      EXE_SH_OP: begin
        w_is_store = 1'b1;
        w_misalign = em_mem_addr[0];
        w_sel      = em_mem_addr[1] ? 4'b0011 : 4'b1100;
        w_st_data  = {2{em_reg2[15:0]}};
      end
      EXE_SW_OP, EXE_SC_OP: begin
        w_is_store = 1'b1;
        w_is_sc    = (em_aluop == EXE_SC_OP);
        w_misalign = |em_mem_addr[1:0];
        w_sel      = 4'b1111;
        w_st_data  = em_reg2;
      end
      default: ;
    endcase
  end

  assign w_is_mem = w_is_load | w_is_store;
  // SC success is decided at issue and latched, so a change in the
  // forwarded LLbit while the access is in flight cannot alter the result.
  assign w_sc_ok  = (r_state == S_IDLE) ? w_llbit : r_sc_ok;
  assign w_go     = w_is_mem & ~w_misalign & ~(w_is_sc & ~w_sc_ok);

  always_comb begin
    w_state_nxt     = r_state;
    w_bus_req_nxt   = r_bus_req;
    w_bus_we_nxt    = r_bus_we;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_sel_nxt   = r_bus_sel;
    w_bus_wdata_nxt = r_bus_wdata;
    w_rdata_nxt     = r_rdata;
    w_sc_ok_nxt     = r_sc_ok;
    mem_reg         = em_reg;
    mem_waddr       = em_waddr;
    mem_wdata       = em_wdata;
    mem_whilo       = em_whilo;
    mem_hi          = em_hi;
    mem_lo          = em_lo;
    mem_LLbit_we    = 1'b0;
    mem_LLbit_value = 1'b0;
    stallreq        = 1'b0;

    case (r_state)
      S_IDLE: begin
        stallreq = w_go;
        if (w_go) begin
          w_state_nxt     = S_BUSY;
          w_bus_req_nxt   = 1'b1;
          w_bus_we_nxt    = w_is_store;
          w_bus_addr_nxt  = {em_mem_addr[31:2], 2'b00};
          w_bus_sel_nxt   = w_sel;
          w_bus_wdata_nxt = w_st_data;
          w_sc_ok_nxt     = w_llbit;
        end
      end
      S_BUSY: begin
        stallreq = 1'b1;
        if (bus.bus_ack) begin
          w_state_nxt   = S_DONE;
          w_bus_req_nxt = 1'b0;
          w_bus_we_nxt  = 1'b0;
          w_rdata_nxt   = bus.bus_rdata;
        end
      end
      S_DONE: begin
        if (stall[4] == NoStop) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_is_mem) begin
      if (w_misalign) begin
        mem_reg   = WriteDisa;
        mem_wdata = '0;
      end else if (w_is_load) begin
        mem_wdata = w_ld_data;
`ifdef LLSC_EN
        if (w_is_ll) begin
          mem_LLbit_we    = 1'b1;
          mem_LLbit_value = 1'b1;
        end
`endif
      end else if (w_is_sc) begin
`ifdef LLSC_EN
        mem_wdata       = {31'd0, w_sc_ok};
        mem_LLbit_we    = w_sc_ok;
        mem_LLbit_value = 1'b0;
`else
        mem_wdata = 32'd1;
`endif
      end
    end

    if (rst) begin
      mem_reg         = WriteDisa;
      mem_waddr       = NOPRegAddr;
      mem_wdata       = '0;
      mem_whilo       = 1'b0;
      mem_hi          = '0;
      mem_lo          = '0;
      mem_LLbit_we    = 1'b0;
      mem_LLbit_value = 1'b0;
      stallreq        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_sel   <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
      r_sc_ok     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_bus_we    <= w_bus_we_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_sel   <= w_bus_sel_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_sc_ok     <= w_sc_ok_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: directed operations with hand-computed results,
// expected responses queued by the stimulus and compared by a monitor.
module tb_mem_access;

  localparam logic [7:0] ADDU = 8'b00100001;
  localparam logic [7:0] LB   = 8'b11100000;
  localparam logic [7:0] LBU  = 8'b11100100;
  localparam logic [7:0] LH   = 8'b11100001;
  localparam logic [7:0] LHU  = 8'b11100101;
  localparam logic [7:0] LW   = 8'b11100011;
  localparam logic [7:0] LL   = 8'b11110000;
  localparam logic [7:0] SB   = 8'b11101000;
  localparam logic [7:0] SH   = 8'b11101001;
  localparam logic [7:0] SC   = 8'b11111000;

  logic        clk = 1'b0;
  logic        rst;
  logic        em_reg;
  logic [4:0]  em_waddr;
  logic [31:0] em_wdata;
  logic        em_whilo;
  logic [31:0] em_hi;
  logic [31:0] em_lo;
  logic [7:0]  em_aluop;
  logic [31:0] em_mem_addr;
  logic [31:0] em_reg2;
  logic [5:0]  stall;
  logic        LLbit_i;
  logic        wb_LLbit_we;
  logic        wb_LLbit_value;
  logic        mem_reg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_LLbit_we;
  logic        mem_LLbit_value;
  logic        stallreq;

  mem_access_if bus_if();

  always #5 clk = ~clk;

  // ctrl behaviour: a MEM stall request freezes stages 0..4.
  assign stall = stallreq ? 6'b011111 : 6'b000000;

  mem_access dut (
    .clk(clk), .rst(rst),
    .em_reg(em_reg), .em_waddr(em_waddr), .em_wdata(em_wdata),
    .em_whilo(em_whilo), .em_hi(em_hi), .em_lo(em_lo),
    .em_aluop(em_aluop), .em_mem_addr(em_mem_addr), .em_reg2(em_reg2),
    .stall(stall), .LLbit_i(LLbit_i),
    .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
    .bus(bus_if),
    .mem_reg(mem_reg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_LLbit_we(mem_LLbit_we), .mem_LLbit_value(mem_LLbit_value),
    .stallreq(stallreq)
  );

  typedef struct {
    logic        regw;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic        llwe;
    logic        llval;
    int unsigned stalls;
    int unsigned nbus;
    logic        pass;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
    logic        chk_wd;
  } bexp_t;

  exp_t  exp_q[$];
  bexp_t bus_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  logic  op_valid = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endfunction

  function automatic void push_exp(logic regw, logic [4:0] wa, logic [31:0] wd,
                                   logic chk, logic llwe, logic llval,
                                   int unsigned stalls, int unsigned nbus, logic pass);
    exp_t e;
    e.regw = regw; e.waddr = wa; e.wdata = wd; e.chk_wdata = chk;
    e.llwe = llwe; e.llval = llval; e.stalls = stalls; e.nbus = nbus; e.pass = pass;
    exp_q.push_back(e);
  endfunction

  function automatic void push_bus(logic [31:0] a, logic [3:0] s, logic we,
                                   logic [31:0] wd, logic chk_wd);
    bexp_t b;
    b.addr = a; b.sel = s; b.we = we; b.wdata = wd; b.chk_wd = chk_wd;
    bus_q.push_back(b);
  endfunction

  // Monitor: bus requests are compared against the bus queue every cycle
  // they are held; results are compared when mem_wb would capture them.
  int unsigned stall_cnt = 0;
  int unsigned req_cnt   = 0;
  logic        prev_req  = 1'b0;
  logic        have_b    = 1'b0;
  bexp_t       cur_b;
  exp_t        m_e;

  always @(negedge clk) begin
    if (bus_if.bus_req && !prev_req) begin
      req_cnt++;
      if (bus_q.size() == 0) begin
        n_chk++; n_fail++; have_b = 1'b0;
        $display("FAIL bus_unexpected: got request addr 0x%08h expected none", bus_if.bus_addr);
      end else begin
        cur_b  = bus_q.pop_front();
        have_b = 1'b1;
      end
    end
    if (bus_if.bus_req && have_b) begin
      check("bus_addr", bus_if.bus_addr, cur_b.addr);
      check("bus_sel", {28'd0, bus_if.bus_sel}, {28'd0, cur_b.sel});
      check("bus_we", {31'd0, bus_if.bus_we}, {31'd0, cur_b.we});
      if (cur_b.chk_wd) check("bus_wdata", bus_if.bus_wdata, cur_b.wdata);
    end
    prev_req = bus_if.bus_req;

    if (rst || !op_valid) begin
      stall_cnt = 0;
      req_cnt   = 0;
    end else if (stallreq) begin
      stall_cnt++;
    end else begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL result_unexpected: got mem_wdata 0x%08h expected no result", mem_wdata);
      end else begin
        m_e = exp_q.pop_front();
        check("mem_reg", {31'd0, mem_reg}, {31'd0, m_e.regw});
        check("mem_waddr", {27'd0, mem_waddr}, {27'd0, m_e.waddr});
        if (m_e.chk_wdata) check("mem_wdata", mem_wdata, m_e.wdata);
        check("mem_LLbit_we", {31'd0, mem_LLbit_we}, {31'd0, m_e.llwe});
        check("mem_LLbit_value", {31'd0, mem_LLbit_value}, {31'd0, m_e.llval});
        check("stall_cycles", stall_cnt, m_e.stalls);
        check("bus_requests", req_cnt, m_e.nbus);
        check("bus_req_at_capture", {31'd0, bus_if.bus_req}, 32'd0);
        if (m_e.pass) begin
          check("mem_whilo", {31'd0, mem_whilo}, {31'd0, em_whilo});
          check("mem_hi", mem_hi, em_hi);
          check("mem_lo", mem_lo, em_lo);
        end
      end
      stall_cnt = 0;
      req_cnt   = 0;
    end
  end

  // Presents one op, acks the bus in cycle ack_cyc (op presented in cycle 0)
  // for ack_hold cycles, and returns at the capture cycle.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic regw,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic [31:0] rdata, input int unsigned ack_cyc,
                        input int unsigned ack_hold);
    int unsigned cyc;
    @(posedge clk); #1;
    em_aluop = op; em_mem_addr = addr; em_reg2 = reg2;
    em_reg = regw; em_waddr = wa; em_wdata = wd;
    bus_if.bus_rdata = rdata; bus_if.bus_ack = 1'b0;
    op_valid = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!stallreq) break;
      if (cyc > 40) begin
        n_chk++; n_fail++;
        $display("FAIL timeout: got stallreq held %0d cycles expected release", cyc);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      bus_if.bus_ack = (cyc >= ack_cyc) && (cyc < ack_cyc + ack_hold);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    em_aluop = ADDU; em_reg = 1'b1; em_waddr = 5'd3; em_wdata = 32'h1234;
    em_whilo = 1'b1; em_hi = 32'hAAAA0001; em_lo = 32'h5555_0002;
    em_mem_addr = 32'h0; em_reg2 = 32'h0;
    LLbit_i = 1'b0; wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
    check("rst_bus_we", {31'd0, bus_if.bus_we}, 32'd0);
    check("rst_bus_addr", bus_if.bus_addr, 32'd0);
    check("rst_bus_sel", {28'd0, bus_if.bus_sel}, 32'd0);
    check("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
    check("rst_stallreq", {31'd0, stallreq}, 32'd0);
    check("rst_mem_reg", {31'd0, mem_reg}, 32'd0);
    check("rst_mem_waddr", {27'd0, mem_waddr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_whilo", {31'd0, mem_whilo}, 32'd0);
    check("rst_mem_hi", mem_hi, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Passthrough, same-cycle result.
    push_exp(1'b1, 5'd3, 32'h1234, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    run_op(ADDU, 32'h0, 32'h0, 1'b1, 5'd3, 32'h1234, 32'h0, 1, 1);

    // Loads: lanes and extension.
    push_bus(32'h100, 4'b0001, 1'b0, 32'h0, 1'b0);
    push_exp(1'b1, 5'd4, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b0, 3, 1, 1'b0);
    run_op(LB, 32'h103, 32'h0, 1'b1, 5'd4, 32'h0, 32'h000000F0, 2, 1);

    push_bus(32'h100, 4'b0100, 1'b0, 32'h0, 1'b0);
    push_exp(1'b1, 5'd7, 32'h000000A2, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0);
    run_op(LBU, 32'h101, 32'h0, 1'b1, 5'd7, 32'h0, 32'h11A23344, 1, 1);

    push_bus(32'h100, 4'b1100, 1'b0, 32'h0, 1'b0);
    push_exp(1'b1, 5'd8, 32'hFFFF8001, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0);
    run_op(LH, 32'h100, 32'h0, 1'b1, 5'd8, 32'h0, 32'h80017FFF, 1, 1);

    push_bus(32'h100, 4'b0011, 1'b0, 32'h0, 1'b0);
    push_exp(1'b1, 5'd9, 32'h0000F00D, 1'b1, 1'b0, 1'b0, 3, 1, 1'b0);
    run_op(LHU, 32'h102, 32'h0, 1'b1, 5'd9, 32'h0, 32'h8001F00D, 2, 1);

    // Ack held high across the DONE cycle.
    push_bus(32'h104, 4'b1111, 1'b0, 32'h0, 1'b0);
    push_exp(1'b1, 5'd10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 4, 1, 1'b0);
    run_op(LW, 32'h104, 32'h0, 1'b1, 5'd10, 32'h0, 32'hDEADBEEF, 3, 2);

    // Stores: lane replication.
    push_bus(32'h100, 4'b0011, 1'b1, 32'hABCDABCD, 1'b1);
    push_exp(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 2, 1, 1'b0);
    run_op(SH, 32'h102, 32'h0000ABCD, 1'b0, 5'd0, 32'h55, 32'h0, 1, 1);

    push_bus(32'h200, 4'b0100, 1'b1, 32'h77777777, 1'b1);
    push_exp(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 2, 1, 1'b0);
    run_op(SB, 32'h201, 32'h12345677, 1'b0, 5'd0, 32'h0, 32'h0, 1, 1);

    // Misaligned: no request, write disabled.
    push_exp(1'b0, 5'd6, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_op(LW, 32'h101, 32'h0, 1'b1, 5'd6, 32'h0, 32'h0, 1, 1);
    push_exp(1'b0, 5'd6, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_op(LH, 32'h103, 32'h0, 1'b1, 5'd6, 32'h0, 32'h0, 1, 1);

    // SC with LLbit forwarded from WB as 1.
    LLbit_i = 1'b0; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    push_bus(32'h300, 4'b1111, 1'b1, 32'hCAFEF00D, 1'b1);
`ifdef LLSC_EN
    push_exp(1'b1, 5'd5, 32'h1, 1'b1, 1'b1, 1'b0, 2, 1, 1'b0);
`else
    push_exp(1'b1, 5'd5, 32'h1, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0);
`endif
    run_op(SC, 32'h300, 32'hCAFEF00D, 1'b1, 5'd5, 32'h0, 32'h0, 1, 1);

    // SC with LLbit 0, then with WB forwarding 0 over LLbit_i=1.
    for (int i = 0; i < 2; i++) begin
      LLbit_i = (i == 1); wb_LLbit_we = (i == 1); wb_LLbit_value = 1'b0;
`ifdef LLSC_EN
      push_exp(1'b1, 5'd5, 32'h0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
`else
      push_bus(32'h300, 4'b1111, 1'b1, 32'hCAFEF00D, 1'b1);
      push_exp(1'b1, 5'd5, 32'h1, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0);
`endif
      run_op(SC, 32'h300, 32'hCAFEF00D, 1'b1, 5'd5, 32'h0, 32'h0, 1, 1);
    end
    wb_LLbit_we = 1'b0; LLbit_i = 1'b0;

    push_bus(32'h400, 4'b1111, 1'b0, 32'h0, 1'b0);
`ifdef LLSC_EN
    push_exp(1'b1, 5'd11, 32'h0BADCAFE, 1'b1, 1'b1, 1'b1, 2, 1, 1'b0);
`else
    push_exp(1'b1, 5'd11, 32'h0BADCAFE, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0);
`endif
    run_op(LL, 32'h400, 32'h0, 1'b1, 5'd11, 32'h0, 32'h0BADCAFE, 1, 1);

    push_exp(1'b1, 5'd12, 32'h77, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    run_op(ADDU, 32'h0, 32'h0, 1'b1, 5'd12, 32'h77, 32'h0, 1, 1);

    // Reset while BUSY, ack arrives after reset.
    @(posedge clk); #1;
    op_valid = 1'b0;
    push_bus(32'h500, 4'b1111, 1'b0, 32'h0, 1'b0);
    em_aluop = LW; em_mem_addr = 32'h500; em_reg = 1'b1; em_waddr = 5'd13;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstbusy_stallreq", {31'd0, stallreq}, 32'd0);
    check("rstbusy_mem_reg", {31'd0, mem_reg}, 32'd0);
    check("rstbusy_mem_waddr", {27'd0, mem_waddr}, 32'd0);
    @(posedge clk); #1;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("rstack_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
    check("rstack_stallreq", {31'd0, stallreq}, 32'd0);
    check("rstack_mem_wdata", mem_wdata, 32'd0);
    check("rstack_mem_reg", {31'd0, mem_reg}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; em_aluop = ADDU; em_reg = 1'b0; em_wdata = 32'h99;
    @(negedge clk);
    check("idle_ack_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
    check("idle_ack_stallreq", {31'd0, stallreq}, 32'd0);
    check("idle_ack_mem_wdata", mem_wdata, 32'h99);
    @(posedge clk); #1;
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    check("post_rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);

    check("exp_queue_drained", exp_q.size(), 32'd0);
    check("bus_queue_drained", bus_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the MIPS pipeline, between the ex_mem pipeline register and the mem_wb pipeline register. It drives a request/acknowledge data bus for loads and stores, and performs byte-lane selection, sign and zero extension, and LL/SC link-bit handling. It holds the pipeline through `stallreq` until the access completes. Results go to mem_wb in mem_wb's input format.

## Interface
- No parameters. Widths come from `RegBus` (32) and `RegAddrBus` (5).
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `em_reg`, `em_waddr`[5], `em_wdata`[32], `em_whilo`, `em_hi`[32], `em_lo`[32]: in. Instruction fields from ex_mem.
- `em_aluop` in 8: operation code.
- `em_mem_addr` in 32: effective address.
- `em_reg2` in 32: store data.
- `stall` in 6: ctrl stall vector. Bit 4 is this stage.
- `LLbit_i` in 1: current LLbit register value.
- `wb_LLbit_we`, `wb_LLbit_value` in 1: LLbit write in progress at WB, used for forwarding.
- `bus_req`, `bus_we` out 1: request strobe and write enable.
- `bus_addr` out 32, word-aligned ({addr[31:2],2'b00}).
- `bus_sel` out 4: byte lane enables.
- `bus_wdata` out 32: write data.
- `bus_ack` in 1: access complete.
- `bus_rdata` in 32: read data, valid with `bus_ack`.
- `mem_reg`, `mem_waddr`, `mem_wdata`, `mem_whilo`, `mem_hi`, `mem_lo`, `mem_LLbit_we`, `mem_LLbit_value`: out. Result to mem_wb.
- `stallreq` out 1: hold request to ctrl.

## Operation
- Memory ops are `EXE_LB/LBU/LH/LHU/LW/LL_OP` and `EXE_SB/SH/SW/SC_OP`. All other aluops pass through combinationally: `mem_*` = `em_*`, LLbit_we=0, stallreq=0, no bus activity.
- Byte lanes are big-endian.
  - Byte at addr[1:0]=00 → lane 3, `bus_sel`=1000. 01→0100, 10→0010, 11→0001.
  - Halfword at addr[1]=0 → 1100. addr[1]=1 → 0011.
  - Word → 1111.
- Store data is replicated across lanes: SB {4{b}}, SH {2{h}}, SW/SC the full word.
- Load data is taken from the selected lane. LB/LH sign-extend; LBU/LHU zero-extend; LW/LL take the full word.
- Misaligned access (halfword with addr[0]=1, word with addr[1:0]≠0): no bus request, `mem_reg`=`WriteDisa`, stallreq=0.
- Effective LLbit = `wb_LLbit_we` ? `wb_LLbit_value` : `LLbit_i`.
- LL: load word; `mem_LLbit_we`=1, `mem_LLbit_value`=1.
- SC, effective LLbit=1: store word; `mem_wdata`=1; LLbit_we=1, value=0.
- SC, effective LLbit=0: no bus access; `mem_wdata`=0; `mem_reg` per em_reg; stallreq=0.
- State machine has three states: IDLE, BUSY, DONE.
  - IDLE: a qualifying memory op asserts stallreq combinationally. Next edge registers bus_req=1 with addr/sel/we/wdata and moves to BUSY.
  - BUSY: stallreq=1 and bus outputs held stable. On `bus_ack`: latch `bus_rdata`, clear bus_req, move to DONE.
  - DONE: stallreq=0; `mem_wdata` comes from the latched data. When `stall[4]`=`NoStop`, move to IDLE; mem_wb captures the result on that same edge.
- `bus_ack` in IDLE or DONE is ignored.

## Timing
- Reset (rst=1 at an edge): state IDLE, bus_req=0, bus_we=0, bus_addr/sel/wdata=0, latched rdata=0.
- While rst=1, all `mem_*` outputs and stallreq are forced to 0 / `WriteDisa` / `NOPRegAddr`.
- Reset during BUSY abandons the access. bus_req is 0 after that edge.
- Non-memory op: 0-cycle latency.
- Memory op presented in cycle 0:
  - bus_req is high from cycle 1.
  - An ack in cycle k (k≥1) gives DONE in cycle k+1, and mem_wb captures at the end of cycle k+1.
  - Minimum 3 cycles in the stage.
- Back-to-back memory ops: the second op sees IDLE in the cycle after DONE. There is no overlap of bus requests.
- bus_req drops on the edge after ack, even if ack is held high.

## Configuration
- `LLSC_EN` defined: LL/SC behave as described above.
- `LLSC_EN` undefined:
  - LL behaves as LW; SC behaves as SW and always writes 1 to rt.
  - `mem_LLbit_we`=0 always.
  - `LLbit_i`, `wb_LLbit_*` are unused.

## Test plan
- ADDU passthrough, em_wdata=0x1234: same-cycle `mem_wdata`=0x1234, stallreq=0, bus_req=0.
- LB at addr 0x103, rdata 0x000000F0, ack after 2 cycles: bus_sel=0001, `mem_wdata`=0xFFFFFFF0, stallreq high for 3 cycles.
- SH at addr 0x102, em_reg2=0xABCD: bus_we=1, bus_sel=0011, bus_wdata=0xABCDABCD, bus_addr=0x100.
- LW at addr 0x101: bus_req never asserts, `mem_reg`=0, stallreq=0.
- SC with LLbit_i=0 but wb_LLbit_we=1 and wb_LLbit_value=1: store issued, `mem_wdata`=1, `mem_LLbit_we`=1, `mem_LLbit_value`=0. Repeat with LLbit=0: no bus access, `mem_wdata`=0.
- rst asserted in BUSY, then ack arrives one cycle later: state IDLE, bus_req=0, ack ignored, outputs zero.
